// File: rtl/mxint_pkg.sv
// Shared MX-INT mantissa types and the output-register state encoding.
package mxint_pkg;

    localparam int unsigned MXINT_MANT_W = 4;
    localparam int unsigned MXINT_PROD_W = 8;

    typedef logic signed [MXINT_MANT_W-1:0] mant_t;
    typedef logic signed [MXINT_PROD_W-1:0] prod_t;

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_e;

endpackage

// File: rtl/mxint_rr_arbiter.sv
// Combinational round-robin grant: the first set request at or after ptr wins.
module mxint_rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    idx,
    output logic               any
);

    logic [ID_W-1:0] k;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        k     = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            k = ID_W'((32'(ptr) + i) % NUM_REQ);
            if (!any && req[k]) begin
                any      = 1'b1;
                grant[k] = 1'b1;
                idx      = k;
            end
        end
    end

endmodule

// File: rtl/mxint_mant_mul_arb.sv
// Shares one signed mantissa multiplier among NUM_REQ requesters behind a
// one-entry output register. Define MXINT_ARB_STATS_EN for grant/stall counters.
module mxint_mant_mul_arb
    import mxint_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned MANT_W  = MXINT_MANT_W,
    parameter int unsigned PROD_W  = MXINT_PROD_W,
    parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic                      ap_clk,
    input  logic                      ap_rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*MANT_W-1:0] req_a,
    input  logic [NUM_REQ*MANT_W-1:0] req_b,
    output logic                      resp_valid,
    input  logic                      resp_ready,
    output logic [ID_W-1:0]           resp_id,
    output logic [PROD_W-1:0]         resp_prod
`ifdef MXINT_ARB_STATS_EN
    ,
    output logic [NUM_REQ*16-1:0]     grant_cnt,
    output logic [15:0]               stall_cnt
`endif
);

    out_state_e          state_q;
    logic [ID_W-1:0]     id_q;
    logic [PROD_W-1:0]   prod_q;
    logic [ID_W-1:0]     ptr_q, ptr_d;
    logic [PROD_W-1:0]   prod_d;

    logic [NUM_REQ-1:0]  grant;
    logic [ID_W-1:0]     gidx;
    logic                gany;
    logic                can_accept;
    logic                hs;
    logic [MANT_W-1:0]   a_sel, b_sel;

    mxint_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .req   (req_valid),
        .ptr   (ptr_q),
        .grant (grant),
        .idx   (gidx),
        .any   (gany)
    );

    assign can_accept = (state_q == OUT_EMPTY) || resp_ready;
    assign req_ready  = grant & {NUM_REQ{can_accept}};
    assign hs         = gany && can_accept;

    // Operand mux keyed on the one-hot grant so req_ready never depends on operands.
    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                a_sel = req_a[i*MANT_W +: MANT_W];
                b_sel = req_b[i*MANT_W +: MANT_W];
            end
        end
    end

    // Sign-extend to full product width; the low PROD_W bits are then exact.
    assign prod_d = {{(PROD_W-MANT_W){a_sel[MANT_W-1]}}, a_sel}
                  * {{(PROD_W-MANT_W){b_sel[MANT_W-1]}}, b_sel};

    assign ptr_d = (gidx == ID_W'(NUM_REQ-1)) ? '0 : gidx + 1'b1;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q <= OUT_EMPTY;
            id_q    <= '0;
            prod_q  <= '0;
            ptr_q   <= '0;
        end else begin
            if (hs) begin
                state_q <= OUT_FULL;
                id_q    <= gidx;
                prod_q  <= prod_d;
                ptr_q   <= ptr_d;
            end else if (state_q == OUT_FULL && resp_ready) begin
                state_q <= OUT_EMPTY;
            end
        end
    end

    assign resp_valid = (state_q == OUT_FULL);
    assign resp_id    = id_q;
    assign resp_prod  = prod_q;

`ifdef MXINT_ARB_STATS_EN
    logic [NUM_REQ-1:0][15:0] grant_cnt_q;
    logic [15:0]              stall_cnt_q;
    logic                     stall;

    assign stall = (state_q == OUT_FULL) && !resp_ready && (|req_valid);

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            grant_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (req_ready[i] && req_valid[i]) begin
                    grant_cnt_q[i] <= grant_cnt_q[i] + 16'd1;
                end
            end
            if (stall && stall_cnt_q != '1) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
        end
    end

    assign grant_cnt = grant_cnt_q;
    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_mxint_mant_mul_arb.sv
// Directed bench for mxint_mant_mul_arb; inputs change 1ns after rising edges,
// outputs are sampled on falling edges.
module tb_mxint_mant_mul_arb;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned MANT_W  = 4;
    localparam int unsigned PROD_W  = 8;
    localparam int unsigned ID_W    = 2;

    logic                      ap_clk = 1'b0;
    logic                      ap_rst_n;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*MANT_W-1:0] req_a;
    logic [NUM_REQ*MANT_W-1:0] req_b;
    logic                      resp_valid;
    logic                      resp_ready;
    logic [ID_W-1:0]           resp_id;
    logic [PROD_W-1:0]         resp_prod;
`ifdef MXINT_ARB_STATS_EN
    logic [NUM_REQ*16-1:0]     grant_cnt;
    logic [15:0]               stall_cnt;
`endif

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    always #5 ap_clk = ~ap_clk;

    mxint_mant_mul_arb #(
        .NUM_REQ (NUM_REQ),
        .MANT_W  (MANT_W),
        .PROD_W  (PROD_W),
        .ID_W    (ID_W)
    ) dut (
        .ap_clk     (ap_clk),
        .ap_rst_n   (ap_rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_prod  (resp_prod)
`ifdef MXINT_ARB_STATS_EN
        ,
        .grant_cnt  (grant_cnt),
        .stall_cnt  (stall_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input int unsigned i, input logic [3:0] a, input logic [3:0] b);
        req_a[i*MANT_W +: MANT_W] = a;
        req_b[i*MANT_W +: MANT_W] = b;
    endtask

    task automatic step();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic do_reset();
        ap_rst_n = 1'b0;
        repeat (2) @(posedge ap_clk);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        step();
    endtask

    initial begin
        ap_rst_n   = 1'b0;
        req_valid  = '0;
        req_a      = '0;
        req_b      = '0;
        resp_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge ap_clk);
        @(negedge ap_clk);
        chk("rst_valid", 32'(resp_valid), 32'd0);
        chk("rst_id",    32'(resp_id),    32'd0);
        chk("rst_prod",  32'(resp_prod),  32'd0);
        chk("rst_ready", 32'(req_ready),  32'd0);
        ap_rst_n = 1'b1;
        step();

        // Single request from requester 2: 3 * -2 = -6
        set_op(2, 4'd3, 4'hE);
        req_valid = 4'b0100;
        @(negedge ap_clk);
        chk("single_ready", 32'(req_ready), 32'h4);
        step();
        req_valid = '0;
        @(negedge ap_clk);
        chk("single_valid", 32'(resp_valid), 32'd1);
        chk("single_id",    32'(resp_id),    32'd2);
        chk("single_prod",  32'(resp_prod),  32'hFA);
        // Pointer moved to 3, so with everyone valid requester 3 wins
        step();
        req_valid = 4'b1111;
        @(negedge ap_clk);
        chk("ptr_after_single", 32'(req_ready), 32'h8);
        step();
        req_valid = '0;
        @(negedge ap_clk);
        chk("ptr_resp_id", 32'(resp_id), 32'd3);

        // All requesters valid from reset: grants 0,1,2,3,0, products 2*(i+1)
        do_reset();
        for (int unsigned i = 0; i < NUM_REQ; i++) set_op(i, 4'(i + 1), 4'd2);
        req_valid  = 4'b1111;
        resp_ready = 1'b1;
        for (int unsigned k = 0; k < 5; k++) begin
            @(negedge ap_clk);
            chk($sformatf("rr_grant%0d", k), 32'(req_ready), 32'(1 << (k % 4)));
            if (k > 0) begin
                chk($sformatf("rr_id%0d", k),   32'(resp_id),   (k - 1) % 4);
                chk($sformatf("rr_prod%0d", k), 32'(resp_prod), 2 * ((k - 1) % 4 + 1));
            end
            step();
        end
        @(negedge ap_clk);
        chk("rr_last_id", 32'(resp_id), 32'd0);

        // Backpressure with -8 * -8 = +64 held in the register; pointer is at 1
        step();
        set_op(1, 4'h8, 4'h8);
        set_op(2, 4'h8, 4'd7);
        set_op(3, 4'd7, 4'd7);
        set_op(0, 4'd0, 4'h8);
        req_valid = 4'b0010;
        @(negedge ap_clk);
        chk("bp_grant1", 32'(req_ready), 32'h2);
        step();
        resp_ready = 1'b0;
        req_valid  = 4'b1111;
        for (int unsigned k = 0; k < 3; k++) begin
            @(negedge ap_clk);
            chk($sformatf("bp_valid%0d", k), 32'(resp_valid), 32'd1);
            chk($sformatf("bp_prod%0d", k),  32'(resp_prod),  32'h40);
            chk($sformatf("bp_id%0d", k),    32'(resp_id),    32'd1);
            chk($sformatf("bp_ready%0d", k), 32'(req_ready),  32'h0);
            step();
        end
        resp_ready = 1'b1;
        @(negedge ap_clk);
        chk("bp_release_grant", 32'(req_ready), 32'h4);
        step();
        @(negedge ap_clk);
        chk("corner_m8x7",  32'(resp_prod), 32'hC8);
        chk("corner_id2",   32'(resp_id),   32'd2);
        chk("corner_next3", 32'(req_ready), 32'h8);
        step();
        @(negedge ap_clk);
        chk("corner_7x7",   32'(resp_prod), 32'h31);
        chk("corner_id3",   32'(resp_id),   32'd3);
        chk("corner_next0", 32'(req_ready), 32'h1);
        step();
        req_valid = '0;
        @(negedge ap_clk);
        chk("corner_0xm8",  32'(resp_prod), 32'h00);
        chk("corner_id0",   32'(resp_id),   32'd0);
        step();
        @(negedge ap_clk);
        chk("drain_valid", 32'(resp_valid), 32'd0);
        chk("drain_id",    32'(resp_id),    32'd0);

        // Mid-stream asynchronous reset while FULL with a nonzero product
        step();
        set_op(3, 4'd7, 4'd7);
        req_valid  = 4'b1000;
        resp_ready = 1'b0;
        step();
        req_valid = '0;
        @(negedge ap_clk);
        chk("pre_rst_valid", 32'(resp_valid), 32'd1);
        chk("pre_rst_prod",  32'(resp_prod),  32'h31);
        #2;
        ap_rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(resp_valid), 32'd0);
        chk("arst_prod",  32'(resp_prod),  32'd0);
        chk("arst_id",    32'(resp_id),    32'd0);
        @(negedge ap_clk);
        ap_rst_n   = 1'b1;
        resp_ready = 1'b1;
        step();
        req_valid = 4'b0110;
        @(negedge ap_clk);
        chk("post_rst_grant", 32'(req_ready), 32'h2);
        step();
        req_valid = '0;

`ifdef MXINT_ARB_STATS_EN
        do_reset();
        chk("stats_rst_stall", 32'(stall_cnt), 32'd0);
        set_op(1, 4'd1, 4'd1);
        req_valid  = 4'b0010;
        resp_ready = 1'b1;
        repeat (10) step();
        resp_ready = 1'b0;
        repeat (5) step();
        req_valid = '0;
        @(negedge ap_clk);
        chk("stats_grant0", 32'(grant_cnt[0 +: 16]),  32'd0);
        chk("stats_grant1", 32'(grant_cnt[16 +: 16]), 32'd10);
        chk("stats_grant2", 32'(grant_cnt[32 +: 16]), 32'd0);
        chk("stats_grant3", 32'(grant_cnt[48 +: 16]), 32'd0);
        chk("stats_stall",  32'(stall_cnt),           32'd5);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mxint_mant_mul_arb.md
# mxint_mant_mul_arb

Round-robin arbiter and sequencer that shares a single signed 4x4 MX-INT mantissa multiplier among NUM_REQ requesters. It sits between the per-lane mantissa producers and the downstream exponent/accumulate stage. It accepts one operand pair per cycle through valid/ready handshakes, multiplies it, and returns the product tagged with the requester index through a one-entry registered output with backpressure.

## Interface
- NUM_REQ, 4: number of requesters, 2..8.
- MANT_W, 4: signed mantissa width.
- PROD_W, 8: signed product width, must be 2*MANT_W.
- ID_W, $clog2(NUM_REQ): width of the requester tag.

Ports:
- ap_clk  in  1  single clock, rising edge.
- ap_rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester operand valid.
- req_ready  out  NUM_REQ  per-requester accept, at most one bit high.
- req_a  in  NUM_REQ*MANT_W  packed signed mantissa A; requester i occupies bits [i*MANT_W +: MANT_W].
- req_b  in  NUM_REQ*MANT_W  packed signed mantissa B, same packing as req_a.
- resp_valid  out  1  product register full.
- resp_ready  in  1  downstream accept.
- resp_id  out  ID_W  index of the requester that issued the product.
- resp_prod  out  PROD_W  signed product.

## Operation
- Output register has two states:
  - EMPTY: resp_valid=0.
  - FULL: resp_valid=1.
- can_accept = EMPTY | (FULL & resp_ready).
- Grant selection:
  - Combinational round-robin over req_valid, starting at rr_ptr.
  - req_ready[i] = grant[i] & can_accept.
- Handshake on requester g (req_valid[g] & req_ready[g]):
  - resp_prod <= signed(a_g) * signed(b_g), computed at full precision.
  - resp_id <= g; state <= FULL.
  - rr_ptr <= (g+1) mod NUM_REQ.
- Drain only (FULL & resp_ready with no new handshake): state <= EMPTY; resp_prod and resp_id hold their last values.
- Same-cycle drain and accept: the register reloads and stays FULL, giving full throughput of one product per cycle.
- rr_ptr changes only on a handshake. Idle cycles and stalled cycles leave it unchanged.
- Requesters must hold valid and operands stable until they see ready. The arbiter does not latch a request that has not been granted.
- While FULL & !resp_ready: all req_ready=0, and resp_valid, resp_id and resp_prod stay stable.
- Product range is -56..+64. Corner cases: -8*-8 = +64 = 0x40 and -8*7 = -56 = 0xC8. No saturation and no truncation.
- Reset values: resp_valid=0, resp_id=0, resp_prod=0, rr_ptr=0, all stats counters 0.
- Reset asserted mid-operation: any in-flight product is discarded, and all outputs return to their reset values immediately (asynchronous).

## Timing
- Latency is 1 cycle: a handshake at edge N gives resp_valid=1 after edge N.
- req_ready depends combinationally on req_valid, rr_ptr, state and resp_ready. It has no combinational dependence on req_a or req_b.
- The multiplier sits between the operand mux and resp_prod. It is a single combinational stage.
- Fairness: with all requesters continuously valid and resp_ready=1, each requester is granted exactly once every NUM_REQ cycles.

## Configuration
- MXINT_ARB_STATS_EN defined:
  - Adds output grant_cnt (NUM_REQ*16), one wrapping 16-bit handshake counter per requester.
  - Adds output stall_cnt (16), which increments each cycle with FULL & !resp_ready & |req_valid, saturating at 0xFFFF.
  - Both reset to 0.
- MXINT_ARB_STATS_EN undefined: the ports and logic do not exist, and the block is otherwise cycle-identical.

## Structure
- Shared package mxint_pkg holds:
  - MXINT_MANT_W=4 and MXINT_PROD_W=8.
  - typedef mant_t (signed [MANT_W-1:0]) and prod_t (signed [PROD_W-1:0]).
  - Output-state enum {OUT_EMPTY, OUT_FULL}.
- One sub-module, mxint_rr_arbiter: a parameterised round-robin grant from a request vector and a pointer, producing a one-hot grant plus encoded index. It is purely combinational.
- The multiply is inferred inline in the top level.

## Test plan
- Single request: requester 2 with a=3, b=-2 and resp_ready=1. Expect req_ready[2]=1 on the same cycle; next cycle resp_valid=1, resp_id=2, resp_prod=0xFA; rr_ptr becomes 3.
- All four requesters held valid with resp_ready=1 from reset. Expect grants in order 0,1,2,3,0, one per cycle, and resp_id following that order one cycle later.
- Backpressure: set resp_ready=0 for 3 cycles while FULL with product 0x40 (-8*-8). Expect resp_prod and resp_id stable, all req_ready=0 and rr_ptr frozen. The first resp_ready=1 cycle drains and accepts the next request in that same cycle.
- Corner arithmetic: a=-8, b=7 gives 0xC8; a=7, b=7 gives 0x31; a=0, b=-8 gives 0x00.
- Reset mid-stream: drop ap_rst_n while FULL, between clock edges. Expect resp_valid=0, resp_prod=0 and resp_id=0 immediately. After release, the first grant goes to the lowest valid index starting from 0.
- MXINT_ARB_STATS_EN: 10 handshakes from requester 1 plus 5 stall cycles. Expect grant_cnt[1]=10, other grant counters 0, and stall_cnt=5.
